sd_sector_buffer: RTL and testbench
===================================

SD_SECTOR_BUFFER -- requirements
Module: sd_sector_buffer

Interface
REQ-001 Parameter SECTOR_BYTES, default 512, bytes per sector; pointer width is 10 bits.
REQ-002 Parameter ADDR_W, default 26, sector address width.
REQ-003 clk  input  1  master clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 host_req  input  1  one-cycle start pulse; sampled only in IDLE.
REQ-006 host_op  input  1  0 = READ, 1 = WRITE; latched with host_req.
REQ-007 host_sector  input  26  sector address; latched with host_req.
REQ-008 host_wr_valid / host_wr_data / host_wr_ready  in/in/out  1/8/1  write-data stream to the buffer.
REQ-009 host_rd_valid / host_rd_data / host_rd_ready  out/out/in  1/8/1  read-data stream from the buffer.
REQ-010 host_busy  output  1  high in every state except IDLE.
REQ-011 host_done  output  1  one-cycle pulse at end of operation.
REQ-012 host_err  output  1  sticky byte-count error; cleared by the next accepted host_req.
REQ-013 sd_op_code / sd_execute / sd_sector_address  out/out/out  1/1/26  command to the SD card controller.
REQ-014 sd_outgoing_byte / sd_incoming_byte  out/in  8/8  byte toward / from the card.
REQ-015 sd_finished_byte / sd_finished_sector / sd_busy  in/in/in  1/1/1  controller status; finished_* are one-cycle pulses.

Function
REQ-016 FSM states: IDLE, FILL, WAIT_RDY, ISSUE, XFER, DRAIN, DONE.
REQ-017 IDLE + host_req: latch op and sector, clear ptr and host_err; WRITE -> FILL, READ -> WAIT_RDY.
REQ-018 FILL: host_wr_ready = 1; each cycle with valid && ready stores the byte at mem[ptr] and increments ptr.
REQ-019 FILL exit: on the transfer with ptr == SECTOR_BYTES-1, deassert ready next cycle and go to WAIT_RDY with ptr = 0.
REQ-020 WAIT_RDY: hold until sd_busy == 0, then ISSUE.
REQ-021 ISSUE: assert sd_execute for exactly one cycle with sd_op_code and sd_sector_address stable; go to XFER.
REQ-022 sd_op_code and sd_sector_address stay stable from ISSUE until DONE.
REQ-023 XFER WRITE: sd_outgoing_byte = mem[ptr], valid from the ISSUE cycle onward; each sd_finished_byte increments ptr, and the next byte is presented within 1 cycle.
REQ-024 XFER READ: each sd_finished_byte writes sd_incoming_byte into mem[ptr] and increments ptr.
REQ-025 Pointer saturation: sd_finished_byte with ptr == SECTOR_BYTES is ignored and sets host_err.
REQ-026 sd_finished_sector in XFER: if ptr != SECTOR_BYTES, set host_err; WRITE -> DONE; READ -> DRAIN with ptr = 0.
REQ-027 If sd_finished_byte and sd_finished_sector arrive in the same cycle, process the byte first, then evaluate the sector-end count including that byte.
REQ-028 DRAIN: host_rd_valid = 1 with host_rd_data = mem[ptr]; on valid && ready increment ptr.
REQ-029 DRAIN handles synchronous RAM read latency by prefetch, so back-to-back ready gives one byte per cycle after the first.
REQ-030 DRAIN exit: after the SECTOR_BYTES-th accepted byte, go to DONE.
REQ-031 DONE: host_done = 1 for one cycle, then IDLE.
REQ-032 host_req outside IDLE is ignored.
REQ-033 host_wr_ready is 0 outside FILL; host_rd_valid is 0 outside DRAIN.

Reset
REQ-034 rst: state IDLE, ptr 0; sd_execute, host_done, host_err, host_busy, host_wr_ready and host_rd_valid all 0.
REQ-035 rst: sd_op_code 0, sd_sector_address 0, sd_outgoing_byte 8'hFF.
REQ-036 rst mid-operation aborts immediately to IDLE; buffer contents are undefined; no sd_execute is issued afterward.

Structure
REQ-037 Shared package sd_pkg holds: OP_READ/OP_WRITE, SECTOR_BYTES, the sector address width, and the FSM state encoding.
REQ-038 Storage is the single sub-module sd_sector_ram: 512x8, single-port, synchronous read, one-cycle latency.

Verification
REQ-039 WRITE sector 26'h000123, host streams bytes 0x00..0xFF twice -> one sd_execute pulse with op = 1 and addr 0x123; controller-model captures the same 512 bytes in order; host_done pulses once; host_err = 0.
REQ-040 READ sector 5, card-model supplies i[7:0] for i = 0..511 -> host receives the identical 512 bytes; host_rd_ready toggled randomly with no loss or duplication.
REQ-041 READ where the model issues sd_finished_sector after 511 bytes -> host_err = 1, DRAIN still entered, and host_err clears on the next host_req.
REQ-042 sd_busy held high 100 cycles after FILL completes -> sd_execute is not pulsed until the cycle after sd_busy falls.
REQ-043 Final sd_finished_byte coincides with sd_finished_sector -> byte is counted and host_err = 0.
REQ-044 rst asserted mid-XFER at ptr = 200 -> next cycle IDLE, all outputs at reset values; a new host_req then completes normally.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared constants, opcode values and FSM state encoding for the SD sector buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sd_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int ADDR_W       = 26;
  localparam int PTR_W        = 10;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WAIT_RDY,
    ST_ISSUE,
    ST_XFER,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sd_sector_buffer_if.sv
// Host-side and card-controller-side signal bundle of the sector buffer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both host byte streams; card side paced by finished_byte pulses.
interface sd_sector_buffer_if #(
  parameter int ADDR_W = sd_pkg::ADDR_W
);
  logic              host_req;
  logic              host_op;
  logic [ADDR_W-1:0] host_sector;
  logic              host_wr_valid;
  logic [7:0]        host_wr_data;
  logic              host_wr_ready;
  logic              host_rd_valid;
  logic [7:0]        host_rd_data;
  logic              host_rd_ready;
  logic              host_busy;
  logic              host_done;
  logic              host_err;
  logic              sd_op_code;
  logic              sd_execute;
  logic [ADDR_W-1:0] sd_sector_address;
  logic [7:0]        sd_outgoing_byte;
  logic [7:0]        sd_incoming_byte;
  logic              sd_finished_byte;
  logic              sd_finished_sector;
  logic              sd_busy;

  // Buffer side
  modport slave (
    input  host_req, host_op, host_sector, host_wr_valid, host_wr_data, host_rd_ready,
    input  sd_incoming_byte, sd_finished_byte, sd_finished_sector, sd_busy,
    output host_wr_ready, host_rd_valid, host_rd_data, host_busy, host_done, host_err,
    output sd_op_code, sd_execute, sd_sector_address, sd_outgoing_byte
  );

  // Host plus card-controller side
  modport master (
    output host_req, host_op, host_sector, host_wr_valid, host_wr_data, host_rd_ready,
    output sd_incoming_byte, sd_finished_byte, sd_finished_sector, sd_busy,
    input  host_wr_ready, host_rd_valid, host_rd_data, host_busy, host_done, host_err,
    input  sd_op_code, sd_execute, sd_sector_address, sd_outgoing_byte
  );
endinterface

// File: rtl/sd_sector_ram.sv
// One-sector byte store, single port, synchronous read (read-before-write).
// Latency: read data valid one cycle after the address is presented.
// Backpressure: none; accepts one access per cycle.
module sd_sector_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Single shared address: write when enabled, always return the old contents
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/sd_sector_buffer.sv
// Sector staging buffer between a byte-stream host and an SD card controller.
// Latency: execute one cycle after card idle; outgoing byte follows finished_byte in the same cycle it updates.
// Backpressure: host streams use valid/ready; drain has a one-cycle prefetch bubble, then one byte per cycle.
module sd_sector_buffer #(
  parameter int SECTOR_BYTES = sd_pkg::SECTOR_BYTES,
  parameter int ADDR_W       = sd_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  sd_sector_buffer_if.slave bus
);
  import sd_pkg::*;

  localparam int               RAM_AW   = $clog2(SECTOR_BYTES);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SECTOR_BYTES - 1);
  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(SECTOR_BYTES);

  state_t            state_q;
  logic              op_q;
  logic [ADDR_W-1:0] sector_q;
  logic              err_q;
  logic              pf_q;
  logic [PTR_W-1:0]  ptr_q, ptr_d, xfer_cnt;
  logic              err_set;
  logic              rd_fire;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [7:0]        ram_wdata, ram_rdata;

  assign rd_fire = bus.host_rd_valid & bus.host_rd_ready;

  // Next pointer; during XFER a same-cycle byte is counted before the sector-end check
  always_comb begin
    xfer_cnt = ptr_q;
    if (bus.sd_finished_byte && ptr_q != PTR_FULL) xfer_cnt = ptr_q + PTR_ONE;
    err_set = (state_q == ST_XFER) &&
              ((bus.sd_finished_byte && ptr_q == PTR_FULL) ||
               (bus.sd_finished_sector && xfer_cnt != PTR_FULL));
    ptr_d = ptr_q;
    case (state_q)
      ST_IDLE:  if (bus.host_req) ptr_d = '0;
      ST_FILL:  if (bus.host_wr_valid) ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_ONE;
      ST_XFER:  ptr_d = bus.sd_finished_sector ? '0 : xfer_cnt;
      ST_DRAIN: if (rd_fire) ptr_d = ptr_q + PTR_ONE;
      default:  ptr_d = ptr_q;
    endcase
  end

  // RAM port: writes use the current pointer, reads look ahead to the next pointer
  // so read data always corresponds to ptr_q one cycle later
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = ptr_d[RAM_AW-1:0];
    ram_wdata = bus.host_wr_data;
    if (state_q == ST_FILL) begin
      ram_we   = bus.host_wr_valid;
      ram_addr = ptr_q[RAM_AW-1:0];
    end else if (state_q == ST_XFER && op_q == OP_READ) begin
      ram_we    = bus.sd_finished_byte && (ptr_q != PTR_FULL);
      ram_addr  = ptr_q[RAM_AW-1:0];
      ram_wdata = bus.sd_incoming_byte;
    end
  end

  sd_sector_ram #(.DEPTH(SECTOR_BYTES)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Control FSM with latched command, sticky error and drain prefetch flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      op_q     <= OP_READ;
      sector_q <= '0;
      err_q    <= 1'b0;
      pf_q     <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      pf_q  <= (state_q == ST_DRAIN);
      if (err_set) err_q <= 1'b1;
      case (state_q)
        ST_IDLE: if (bus.host_req) begin
          op_q     <= bus.host_op;
          sector_q <= bus.host_sector;
          err_q    <= 1'b0;
          state_q  <= (bus.host_op == OP_WRITE) ? ST_FILL : ST_WAIT_RDY;
        end
        ST_FILL:     if (bus.host_wr_valid && ptr_q == PTR_LAST) state_q <= ST_WAIT_RDY;
        ST_WAIT_RDY: if (!bus.sd_busy) state_q <= ST_ISSUE;
        ST_ISSUE:    state_q <= ST_XFER;
        ST_XFER:     if (bus.sd_finished_sector)
                       state_q <= (op_q == OP_WRITE) ? ST_DONE : ST_DRAIN;
        ST_DRAIN:    if (rd_fire && ptr_q == PTR_LAST) state_q <= ST_DONE;
        ST_DONE:     state_q <= ST_IDLE;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.host_busy         = (state_q != ST_IDLE);
  assign bus.host_done         = (state_q == ST_DONE);
  assign bus.host_err          = err_q;
  assign bus.host_wr_ready     = (state_q == ST_FILL);
  assign bus.host_rd_valid     = (state_q == ST_DRAIN) && pf_q;
  assign bus.host_rd_data      = bus.host_rd_valid ? ram_rdata : 8'h00;
  assign bus.sd_execute        = (state_q == ST_ISSUE);
  assign bus.sd_op_code        = op_q;
  assign bus.sd_sector_address = sector_q;
  assign bus.sd_outgoing_byte  = (op_q == OP_WRITE && (state_q == ST_ISSUE || state_q == ST_XFER))
                                 ? ram_rdata : 8'hFF;

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Directed-plus-random bench for sd_sector_buffer with queue-based host/card reference model.
// Latency: n/a.
// Backpressure: host ready/valid and card byte pacing are randomised.
module tb_sd_sector_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sd_sector_buffer_if bus ();

  sd_sector_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int exec_cnt = 0;
  int done_cnt = 0;
  logic [7:0] wq[$];   // bytes the host handed over for the current write
  logic [7:0] rq[$];   // bytes the card delivered for the current read
  int e0, d0;
  logic [25:0] sec;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.sd_execute) exec_cnt++;
    if (bus.host_done) done_cnt++;
  endtask

  task automatic check_reset(input string p);
    chk({p, "_busy"},     bus.host_busy, 0);
    chk({p, "_done"},     bus.host_done, 0);
    chk({p, "_err"},      bus.host_err, 0);
    chk({p, "_exec"},     bus.sd_execute, 0);
    chk({p, "_wr_ready"}, bus.host_wr_ready, 0);
    chk({p, "_rd_valid"}, bus.host_rd_valid, 0);
    chk({p, "_op"},       bus.sd_op_code, 0);
    chk({p, "_addr"},     bus.sd_sector_address, 0);
    chk({p, "_outbyte"},  bus.sd_outgoing_byte, 8'hFF);
  endtask

  task automatic issue(input logic op, input logic [25:0] s);
    bus.host_req = 1'b1; bus.host_op = op; bus.host_sector = s;
    tick();
    bus.host_req = 1'b0; bus.host_op = 1'b0; bus.host_sector = '0;
    chk("req_busy", bus.host_busy, 1);
    chk("req_err_clear", bus.host_err, 0);
  endtask

  task automatic host_fill(input bit counting);
    int idx = 0;
    int guard = 0;
    logic v, r;
    logic [7:0] d;
    wq.delete();
    while (idx < 512 && guard < 4000) begin
      r = bus.host_wr_ready;
      v = ($urandom_range(3) != 0);
      d = counting ? idx[7:0] : 8'($urandom);
      bus.host_wr_valid = v; bus.host_wr_data = d;
      tick(); guard++;
      if (v && r) begin wq.push_back(d); idx++; end
    end
    bus.host_wr_valid = 1'b0;
    chk("fill_count", idx, 512);
    chk("fill_ready_low", bus.host_wr_ready, 0);
  endtask

  task automatic wait_exec(input logic op, input logic [25:0] s);
    int guard = 0;
    while (!bus.sd_execute && guard < 300) begin tick(); guard++; end
    chk("exec_seen", bus.sd_execute, 1);
    chk("exec_op", bus.sd_op_code, op);
    chk("exec_addr", bus.sd_sector_address, s);
    if (op) chk("issue_byte", bus.sd_outgoing_byte, wq[0]);
    tick();
    chk("exec_one_cycle", bus.sd_execute, 0);
  endtask

  task automatic card_write(input int n, input logic [25:0] s);
    int bad = 0;
    int unstable = 0;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(2)) tick();
      if (bus.sd_outgoing_byte !== wq[k]) bad++;
      if (bus.sd_op_code !== 1'b1 || bus.sd_sector_address !== s) unstable++;
      bus.sd_finished_byte = 1'b1;
      tick();
      bus.sd_finished_byte = 1'b0;
    end
    chk("card_write_bytes_bad", bad, 0);
    chk("card_write_cmd_unstable", unstable, 0);
  endtask

  task automatic card_read(input int n, input bit coincide, input bit counting);
    logic [7:0] d;
    rq.delete();
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(2)) tick();
      d = counting ? k[7:0] : 8'($urandom);
      if (k < 512) rq.push_back(d);
      bus.sd_incoming_byte = d;
      bus.sd_finished_byte = 1'b1;
      if (coincide && k == n - 1) bus.sd_finished_sector = 1'b1;
      tick();
      bus.sd_finished_byte = 1'b0; bus.sd_finished_sector = 1'b0;
    end
    if (!coincide) sector_pulse();
  endtask

  task automatic sector_pulse();
    repeat ($urandom_range(2)) tick();
    bus.sd_finished_sector = 1'b1;
    tick();
    bus.sd_finished_sector = 1'b0;
  endtask

  task automatic host_drain(input int n_valid);
    int idx = 0;
    int bad = 0;
    int guard = 0;
    logic v, r;
    logic [7:0] d;
    while (!bus.host_done && guard < 4000) begin
      v = bus.host_rd_valid; d = bus.host_rd_data;
      r = ($urandom_range(1) == 1);
      bus.host_rd_ready = r;
      tick(); guard++;
      if (v && r) begin
        if (idx < n_valid && d !== rq[idx]) bad++;
        idx++;
      end
    end
    bus.host_rd_ready = 1'b0;
    chk("drain_count", idx, 512);
    chk("drain_data_bad", bad, 0);
  endtask

  task automatic finish_op(input logic exp_err, input int ex0, input int dn0);
    int guard = 0;
    while (!bus.host_done && guard < 50) begin tick(); guard++; end
    chk("done_pulse", bus.host_done, 1);
    chk("done_err", bus.host_err, exp_err);
    tick();
    chk("done_one_cycle", bus.host_done, 0);
    chk("back_idle", bus.host_busy, 0);
    chk("done_count", done_cnt - dn0, 1);
    chk("exec_count", exec_cnt - ex0, 1);
  endtask

  initial begin
    bus.host_req = 0; bus.host_op = 0; bus.host_sector = '0;
    bus.host_wr_valid = 0; bus.host_wr_data = '0; bus.host_rd_ready = 0;
    bus.sd_incoming_byte = '0; bus.sd_finished_byte = 0; bus.sd_finished_sector = 0;
    bus.sd_busy = 0;
    rst = 1'b1;
    repeat (3) tick();
    check_reset("rst");
    rst = 1'b0;
    tick();

    // WRITE sector 0x123, counting pattern twice
    e0 = exec_cnt; d0 = done_cnt;
    issue(1'b1, 26'h123); host_fill(1'b1); wait_exec(1'b1, 26'h123);
    card_write(512, 26'h123); sector_pulse(); finish_op(1'b0, e0, d0);

    // READ sector 5, card supplies i[7:0]
    e0 = exec_cnt; d0 = done_cnt;
    issue(1'b0, 26'd5); wait_exec(1'b0, 26'd5);
    card_read(512, 1'b0, 1'b1); host_drain(512); finish_op(1'b0, e0, d0);

    // Short READ: sector end after 511 bytes
    sec = 26'($urandom); e0 = exec_cnt; d0 = done_cnt;
    issue(1'b0, sec); wait_exec(1'b0, sec);
    card_read(511, 1'b0, 1'b0); host_drain(511); finish_op(1'b1, e0, d0);

    // READ with last byte and sector end together; request clears the sticky error
    sec = 26'($urandom); e0 = exec_cnt; d0 = done_cnt;
    issue(1'b0, sec); wait_exec(1'b0, sec);
    card_read(512, 1'b1, 1'b0); host_drain(512); finish_op(1'b0, e0, d0);

    // READ with one extra byte beyond the sector: ignored, flags error
    sec = 26'($urandom); e0 = exec_cnt; d0 = done_cnt;
    issue(1'b0, sec); wait_exec(1'b0, sec);
    card_read(513, 1'b0, 1'b0); host_drain(512); finish_op(1'b1, e0, d0);

    // WRITE with card busy for 100 cycles after fill, plus a stray request
    sec = 26'($urandom); e0 = exec_cnt; d0 = done_cnt;
    bus.sd_busy = 1'b1;
    issue(1'b1, sec); host_fill(1'b0);
    for (int i = 0; i < 100; i++) begin
      if (i == 10) begin bus.host_req = 1'b1; bus.host_op = 1'b0; bus.host_sector = '1; end
      tick();
      bus.host_req = 1'b0; bus.host_op = 1'b0; bus.host_sector = '0;
    end
    chk("busy_hold_no_exec", exec_cnt - e0, 0);
    chk("busy_hold_busy", bus.host_busy, 1);
    bus.sd_busy = 1'b0;
    tick();
    chk("exec_after_busy_fall", bus.sd_execute, 1);
    wait_exec(1'b1, sec);
    card_write(512, sec); sector_pulse(); finish_op(1'b0, e0, d0);

    // Reset in the middle of a write transfer at pointer 200
    sec = 26'($urandom);
    issue(1'b1, sec); host_fill(1'b0); wait_exec(1'b1, sec);
    card_write(200, sec);
    rst = 1'b1;
    tick();
    check_reset("midrst");
    rst = 1'b0;
    e0 = exec_cnt;
    repeat (20) tick();
    chk("no_exec_after_rst", exec_cnt - e0, 0);

    // Normal write after the abort
    sec = 26'($urandom); e0 = exec_cnt; d0 = done_cnt;
    issue(1'b1, sec); host_fill(1'b0); wait_exec(1'b1, sec);
    card_write(512, sec); sector_pulse(); finish_op(1'b0, e0, d0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
